// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Control sequencer for the multicycle 20-bit-instruction / 64-bit-word core.
// A registered state plus an opcode class (latched in DECODE) drive every
// datapath select and enable. The sequencer waits on a variable-latency
// memory handshake with an optional timeout. It gates instruction issue with
// `run`, parks in sticky HALT / FAULT states and counts retired instructions.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode              IR opcode field, sampled only in DECODE
//   run                 instruction issue enable (checked in IDLE and at completion)
//   mem_ready           memory completes the current request this cycle
//   mem_req/mem_we      memory request valid / request is a write
//   mem_get_data        address mux: 0 = PC, 1 = ALUOut
//   ir_write, pc_write  IR load / unconditional PC write
//   pc_write_cond       PC write when the ALU LSB is 1
//   pc_src              0 = ALUOut, 1 = jump address, 2 = ALU direct
//   alu_src_a/b, alu_op ALU operand muxes and operation (0 add, 1 compare-eq)
//   reg_write, reg_write_data_sel, reg_track_sel   register file controls
//   state               current state encoding
//   halted, fault       sticky HALT / FAULT indicators
//   retired             saturating completed-instruction counter
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int OP_SIZE     = 6,
  parameter int ALU_OP_SIZE = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_SIZE-1:0]     opcode,
  input  logic                   run,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_get_data,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_src,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALU_OP_SIZE-1:0] alu_op,
  output logic                   reg_write,
  output logic [1:0]             reg_write_data_sel,
  output logic                   reg_track_sel,
  output logic [3:0]             state,
  output logic                   halted,
  output logic                   fault,
  output logic [CNT_WIDTH-1:0]   retired
);

  // Wait counter only needs to reach MEM_TIMEOUT; one bit when timeout is off.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  localparam logic [ALU_OP_SIZE-1:0] ALU_ADD    = '0;
  localparam logic [ALU_OP_SIZE-1:0] ALU_CMP_EQ = ALU_OP_SIZE'(1);

  localparam logic [OP_SIZE-1:0] OP_LOAD  = OP_SIZE'(32'h01);
  localparam logic [OP_SIZE-1:0] OP_STORE = OP_SIZE'(32'h02);
  localparam logic [OP_SIZE-1:0] OP_ADD   = OP_SIZE'(32'h03);
  localparam logic [OP_SIZE-1:0] OP_ADDI  = OP_SIZE'(32'h04);
  localparam logic [OP_SIZE-1:0] OP_LOADI = OP_SIZE'(32'h05);
  localparam logic [OP_SIZE-1:0] OP_BEQ   = OP_SIZE'(32'h06);
  localparam logic [OP_SIZE-1:0] OP_JUMP  = OP_SIZE'(32'h07);
  localparam logic [OP_SIZE-1:0] OP_HALT  = OP_SIZE'(32'h3F);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_ACCESS = 4'd4,
    S_MEM_WB     = 4'd5,
    S_ALU_EXEC   = 4'd6,
    S_ALU_WB     = 4'd7,
    S_BRANCH     = 4'd8,
    S_JUMP       = 4'd9,
    S_LOADI_WB   = 4'd10,
    S_HALT       = 4'd11,
    S_FAULT      = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_LOAD, CLS_STORE, CLS_ADD, CLS_ADDI,
    CLS_LOADI, CLS_BEQ, CLS_JUMP, CLS_HALT, CLS_ILLEGAL
  } cls_e;

  function automatic cls_e decode_class(input logic [OP_SIZE-1:0] op);
    cls_e c;
    case (op)
      OP_LOAD:  c = CLS_LOAD;
      OP_STORE: c = CLS_STORE;
      OP_ADD:   c = CLS_ADD;
      OP_ADDI:  c = CLS_ADDI;
      OP_LOADI: c = CLS_LOADI;
      OP_BEQ:   c = CLS_BEQ;
      OP_JUMP:  c = CLS_JUMP;
      OP_HALT:  c = CLS_HALT;
      default:  c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  state_e                state_q, state_d;
  cls_e                  cls_q, cls_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;

  logic complete;     // instruction finished this cycle
  logic retire;       // bump the retired counter at this edge
  logic timeout_hit;  // wait budget for the current access is used up

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);

  // ---------------------------------------------------------------------------
  // Next-state, class latch, wait counter and retire logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d  = state_q;
    cls_d    = cls_q;
    wait_d   = wait_q;
    complete = 1'b0;
    retire   = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;

      S_FETCH: begin
        // A ready on the limit cycle still wins over the timeout.
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FAULT;
      end

      S_DECODE: begin
        cls_d = decode_class(opcode);
        case (cls_d)
          CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
          CLS_ADD, CLS_ADDI:   state_d = S_ALU_EXEC;
          CLS_LOADI:           state_d = S_LOADI_WB;
          CLS_BEQ:             state_d = S_BRANCH;
          CLS_JUMP:            state_d = S_JUMP;
          CLS_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default:             state_d = S_FAULT;
        endcase
      end

      S_MEM_ADDR: state_d = S_MEM_ACCESS;

      S_MEM_ACCESS: begin
        if (mem_ready) begin
          if (cls_q == CLS_STORE) complete = 1'b1;
          else                    state_d  = S_MEM_WB;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end

      S_ALU_EXEC: state_d = S_ALU_WB;

      S_MEM_WB, S_ALU_WB, S_LOADI_WB, S_BRANCH, S_JUMP: complete = 1'b1;

      S_HALT, S_FAULT: ;  // sticky until reset

      default: state_d = S_FAULT;  // unused encodings 13..15
    endcase

    if (complete) begin
      retire  = 1'b1;
      state_d = run ? S_FETCH : S_IDLE;
    end

    // The counter restarts whenever a new state (FETCH / MEM_ACCESS) is entered
    // and only advances while a request is outstanding and unanswered.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((MEM_TIMEOUT != 0) && mem_req && !mem_ready && !timeout_hit) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    retired_d = retired_q;
    if (retire && (retired_q != '1)) retired_d = retired_q + CNT_WIDTH'(1);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= CLS_NONE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: Moore on the registered state and class, except the
  // FETCH IR/PC write strobes, which are gated by mem_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_get_data       = 1'b0;
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    pc_write_cond      = 1'b0;
    pc_src             = 2'd0;
    alu_src_a          = 1'b0;
    alu_src_b          = 2'd0;
    alu_op             = ALU_ADD;
    reg_write          = 1'b0;
    reg_write_data_sel = 2'd0;
    halted             = 1'b0;
    fault              = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        // PC + 4 goes straight from the ALU into the PC as the IR loads.
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
      end
      S_DECODE: alu_src_b = 2'd2;  // speculative branch target into ALUOut
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd3;
      end
      S_MEM_ACCESS: begin
        mem_req      = 1'b1;
        mem_get_data = 1'b1;
        mem_we       = (cls_q == CLS_STORE);
      end
      S_MEM_WB: reg_write = 1'b1;
      S_ALU_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (cls_q == CLS_ADD) ? 2'd1 : 2'd3;
      end
      S_ALU_WB: begin
        reg_write          = 1'b1;
        reg_write_data_sel = 2'd1;
      end
      S_LOADI_WB: begin
        reg_write          = 1'b1;
        reg_write_data_sel = 2'd2;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd1;
        alu_op        = ALU_CMP_EQ;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign reg_track_sel = (cls_q == CLS_ADD) &&
                         (state_q >= S_MEM_ADDR) && (state_q <= S_LOADI_WB);
  assign state         = state_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Scoreboard bench: each driven cycle pushes the expected output bundle, which
// a negedge monitor pops and compares against the DUT. Instruction sequences
// are spelled out per opcode from the state/CPI table. Scenario tasks add
// their own inline checks for counters, sticky flags and async reset.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          run;
  logic          mem_ready;
  logic          mem_req, mem_we, mem_get_data, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_src;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [3:0]    alu_op;
  logic          reg_write;
  logic [1:0]    reg_write_data_sel;
  logic          reg_track_sel;
  logic [3:0]    state;
  logic          halted, fault;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .OP_SIZE(6), .ALU_OP_SIZE(4), .MEM_TIMEOUT(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .run(run), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_get_data(mem_get_data),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write),
    .reg_write_data_sel(reg_write_data_sel), .reg_track_sel(reg_track_sel),
    .state(state), .halted(halted), .fault(fault), .retired(retired)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          mem_req;
    logic          mem_we;
    logic          mem_get_data;
    logic          ir_write;
    logic          pc_write;
    logic          pc_write_cond;
    logic [1:0]    pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [3:0]    alu_op;
    logic          reg_write;
    logic [1:0]    sel;
    logic          track;
    logic          halted;
    logic          fault;
    logic [CW-1:0] retired;
  } obs_t;

  obs_t          sb_q[$];
  obs_t          mon_e, mon_a;
  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;
  logic [CW-1:0] exp_ret     = '0;
  logic          run_now     = 1'b0;
  int            drop_state  = -1;

  // Expected outputs for a state, from the per-state output table.
  function automatic obs_t expect_for(input int st, input int cls, input logic rdy,
                                      input logic [CW-1:0] ret);
    obs_t e;
    e         = '0;
    e.st      = 4'(st);
    e.retired = ret;
    case (st)
      1: begin
        e.mem_req = 1'b1;
        if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd2; end
      end
      2: e.alu_src_b = 2'd2;
      3: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd3; end
      4: begin e.mem_req = 1'b1; e.mem_get_data = 1'b1; e.mem_we = (cls == 2); end
      5: e.reg_write = 1'b1;
      6: begin e.alu_src_a = 1'b1; e.alu_src_b = (cls == 3) ? 2'd1 : 2'd3; end
      7: begin e.reg_write = 1'b1; e.sel = 2'd1; end
      8: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 4'd1; e.pc_write_cond = 1'b1;
      end
      9: begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
      10: begin e.reg_write = 1'b1; e.sel = 2'd2; end
      11: e.halted = 1'b1;
      12: e.fault = 1'b1;
      default: ;
    endcase
    e.track = (st >= 3) && (st <= 10) && (cls == 3);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a = '0;
    a.st = state; a.mem_req = mem_req; a.mem_we = mem_we; a.mem_get_data = mem_get_data;
    a.ir_write = ir_write; a.pc_write = pc_write; a.pc_write_cond = pc_write_cond;
    a.pc_src = pc_src; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.alu_op = alu_op;
    a.reg_write = reg_write; a.sel = reg_write_data_sel; a.track = reg_track_sel;
    a.halted = halted; a.fault = fault; a.retired = retired;
    return a;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Scoreboard side: compare one expected bundle per cycle, away from posedge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_a = sample();
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL cycle%0d outputs: state %0d got %h, required state %0d %h",
                 cyc, mon_a.st, mon_a, mon_e.st, mon_e);
      end
    end
  end

  // One clock of stimulus; the opcode is only meaningful in DECODE, so it is
  // randomised elsewhere to prove the class latch is what later states use.
  task automatic drive(input logic rdy, input logic [5:0] op, input int st);
    if (st == drop_state) run_now = 1'b0;
    run       = run_now;
    mem_ready = rdy;
    opcode    = (st == 2) ? op : 6'($urandom);
    sb_q.push_back(expect_for(st, int'(op), rdy, exp_ret));
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH; fw/mw = wait cycles before mem_ready in FETCH/MEM_ACCESS.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i <= fw; i++) drive(i == fw, op, 1);
    drive(rnd(), op, 2);
    case (op)
      6'h01, 6'h02: begin
        drive(rnd(), op, 3);
        for (int i = 0; i <= mw; i++) drive(i == mw, op, 4);
        if (op == 6'h01) drive(rnd(), op, 5);
        exp_ret++;
      end
      6'h03, 6'h04: begin drive(rnd(), op, 6); drive(rnd(), op, 7); exp_ret++; end
      6'h05: begin drive(rnd(), op, 10); exp_ret++; end
      6'h06: begin drive(rnd(), op, 8); exp_ret++; end
      6'h07: begin drive(rnd(), op, 9); exp_ret++; end
      6'h3F: begin exp_ret++; drive(rnd(), op, 11); end
      default: drive(rnd(), op, 12);
    endcase
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    run_now    = 1'b0;
    run        = 1'b0;
    mem_ready  = 1'b0;
    opcode     = '0;
    drop_state = -1;
    exp_ret    = '0;
    #1;
    vectors++;
    if (sample() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required all zero", sample());
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) drive(rnd(), 6'h05, 0);  // run=0 keeps it idle
  endtask

  task automatic test_loadi();
    run_now = 1'b1;
    drive(rnd(), 6'h05, 0);
    run_instr(6'h05, 0, 0);
    vectors++;
    if (state !== 4'd1 || retired !== 32'd1) begin
      miscompares++;
      $display("FAIL loadi_retire: state %0d retired %0d, required state 1 retired 1",
               state, retired);
    end
  endtask

  task automatic test_load_wait();
    run_instr(6'h01, 0, 3);  // 8 cycles FETCH to FETCH
    vectors++;
    if (state !== 4'd1 || retired !== 32'd2) begin
      miscompares++;
      $display("FAIL load_wait: state %0d retired %0d, required state 1 retired 2",
               state, retired);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(6'h02, 0, 0);
    run_instr(6'h04, 1, 0);
    run_instr(6'h03, 2, 0);
    run_instr(6'h06, 0, 0);
    run_instr(6'h07, 0, 0);
    run_instr(6'h02, 4, 4);  // ready arrives exactly at the wait limit
    run_instr(6'h01, 0, 4);
    vectors++;
    if (retired !== 32'd9 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: retired %0d fault %0d, required retired 9 fault 0",
               retired, fault);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    run_now = 1'b1;
    drive(rnd(), 6'h03, 0);
    run_instr(6'h03, 0, 0);
    run_instr(6'h03, 0, 0);
    run_instr(6'h3F, 0, 0);
    for (int i = 0; i < 20; i++) begin
      run_now = rnd();
      drive(rnd(), 6'h05, 11);
    end
    vectors++;
    if (halted !== 1'b1 || retired !== 32'd3 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_sticky: halted %0d retired %0d, required halted 1 retired 3",
               halted, retired);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    run_now = 1'b1;
    drive(rnd(), 6'h2A, 0);
    run_instr(6'h2A, 0, 0);
    repeat (5) drive(rnd(), 6'h05, 12);
    vectors++;
    if (fault !== 1'b1 || retired !== 32'd0) begin
      miscompares++;
      $display("FAIL illegal_fault: fault %0d retired %0d, required fault 1 retired 0",
               fault, retired);
    end
  endtask

  task automatic test_timeout();
    // FETCH: four tolerated waits, the fifth unanswered cycle faults.
    apply_reset();
    run_now = 1'b1;
    drive(rnd(), 6'h05, 0);
    repeat (5) drive(1'b0, 6'h05, 1);
    for (int i = 0; i < 10; i++) begin
      run_now = rnd();
      drive(rnd(), 6'h05, 12);
    end
    vectors++;
    if (fault !== 1'b1 || retired !== 32'd0) begin
      miscompares++;
      $display("FAIL fetch_timeout: fault %0d retired %0d, required fault 1 retired 0",
               fault, retired);
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (fault !== 1'b0 || state !== 4'd0) begin
      miscompares++;
      $display("FAIL fault_clear: fault %0d state %0d, required fault 0 state 0",
               fault, state);
    end
    // MEM_ACCESS timeout during a LOAD.
    apply_reset();
    run_now = 1'b1;
    drive(rnd(), 6'h01, 0);
    drive(1'b1, 6'h01, 1);
    drive(rnd(), 6'h01, 2);
    drive(rnd(), 6'h01, 3);
    repeat (5) drive(1'b0, 6'h01, 4);
    repeat (3) drive(rnd(), 6'h01, 12);
    vectors++;
    if (fault !== 1'b1 || retired !== 32'd0) begin
      miscompares++;
      $display("FAIL mem_timeout: fault %0d retired %0d, required fault 1 retired 0",
               fault, retired);
    end
  endtask

  task automatic test_async_abort();
    apply_reset();
    run_now = 1'b1;
    drive(rnd(), 6'h05, 0);
    drive(1'b0, 6'h05, 1);  // FETCH outstanding on the next cycle too
    mem_ready = 1'b0;
    #2;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: mem_req %0d, required 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || state !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_drop: mem_req %0d state %0d, required 0 and 0", mem_req, state);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_ret = '0;
    drive(rnd(), 6'h05, 0);
    run_instr(6'h05, 0, 0);
  endtask

  task automatic test_run_drop();
    apply_reset();
    run_now = 1'b1;
    drive(rnd(), 6'h03, 0);
    drop_state = 6;
    run_instr(6'h03, 0, 0);
    drop_state = -1;
    vectors++;
    if (state !== 4'd0 || retired !== 32'd1) begin
      miscompares++;
      $display("FAIL run_drop_park: state %0d retired %0d, required state 0 retired 1",
               state, retired);
    end
    repeat (4) drive(rnd(), 6'h05, 0);
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_load_wait();
    test_back_to_back();
    test_halt();
    test_illegal();
    test_timeout();
    test_async_abort();
    test_run_drop();
    @(posedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
